keypad_emulator: RTL and testbench

Drives the row side of the 4x4 matrix keypad interface. It watches the scanner's column strobes and answers with row levels, as a pulled-down physical keypad would. Keycodes are queued through a valid/ready port and "pressed" one at a time for a programmable hold time, followed by a release gap. The block is used for loopback self-test of the keypad scanner and for scripted key injection from the CPU side.

---
 rtl/keypad_emulator.sv | 144 ++++++++++++++
 tb/tb_keypad_emulator.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_emulator.sv
// Row-side emulator for a 4x4 pulled-down matrix keypad: queues keycodes and presses them one at a time.
// Optional ABORT port (flush queue, release key) is built when KEYPAD_EMU_ABORT_EN is defined.
module keypad_emulator #(
  parameter int HOLD_CYCLES = 5000000,
  parameter int GAP_CYCLES  = 5000000,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] key_in,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic [4:0] code,
  output logic       active,
  output logic       busy
`ifdef KEYPAD_EMU_ABORT_EN
  ,
  input  logic       abort
`endif
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD   = CW'(GAP_CYCLES - 1);
  localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, PRESS, GAP} state_t;

  state_t        state;
  logic [CW-1:0] counter;
  logic [4:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [4:0]    head;
  logic          push;
  logic          pop;
  logic          clear;

`ifdef KEYPAD_EMU_ABORT_EN
  assign clear = abort;
`else
  assign clear = 1'b0;
`endif

  // Returns {column mask, row mask} for a keycode; bit0 = column/row 1.
  function automatic logic [7:0] key_masks(input logic [3:0] k);
    logic [7:0] m;
    case (k)
      4'h0:    m = {4'b0010, 4'b1000};
      4'h1:    m = {4'b0001, 4'b0001};
      4'h2:    m = {4'b0010, 4'b0001};
      4'h3:    m = {4'b0100, 4'b0001};
      4'h4:    m = {4'b0001, 4'b0010};
      4'h5:    m = {4'b0010, 4'b0010};
      4'h6:    m = {4'b0100, 4'b0010};
      4'h7:    m = {4'b0001, 4'b0100};
      4'h8:    m = {4'b0010, 4'b0100};
      4'h9:    m = {4'b0100, 4'b0100};
      4'hA:    m = {4'b1000, 4'b0001};
      4'hB:    m = {4'b1000, 4'b0010};
      4'hC:    m = {4'b1000, 4'b0100};
      4'hD:    m = {4'b1000, 4'b1000};
      4'hE:    m = {4'b0001, 4'b1000};
      default: m = {4'b0100, 4'b1000};
    endcase
    return m;
  endfunction

  logic [7:0] masks;
  assign masks = key_masks(code[3:0]);

  assign head      = mem[rd_ptr];
  assign key_ready = (count != FULL_COUNT);
  assign push      = key_valid && key_ready && !clear;
  assign pop       = (state == IDLE) && (count != '0) && !clear;
  assign active    = (state == PRESS);
  assign busy      = (count != '0) || (state != IDLE);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= key_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Codes without bit4 are popped and dropped while staying in IDLE.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state   <= IDLE;
      counter <= '0;
      code    <= '0;
      rows    <= '0;
    end else begin
      rows <= ((state == PRESS) && ((cols & masks[7:4]) != 4'b0000)) ? masks[3:0] : 4'b0000;
      case (state)
        IDLE: begin
          if (pop && head[4]) begin
            code    <= head;
            counter <= HOLD_LOAD;
            state   <= PRESS;
          end
        end
        PRESS: begin
          if (counter == '0) begin
            code    <= '0;
            counter <= GAP_LOAD;
            state   <= GAP;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        GAP: begin
          if (counter == '0) begin
            state <= IDLE;
          end else begin
            counter <= counter - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// Self-checking bench for keypad_emulator: directed table, corner sequences and random traffic vs a timing model.
module tb_keypad_emulator;
  localparam int HOLD  = 8;
  localparam int GAP   = 4;
  localparam int DEPTH = 4;

  // Physical key map indexed [column][row].
  localparam logic [4:0] KEYMAP [4][4] = '{
    '{5'h11, 5'h14, 5'h17, 5'h1E},
    '{5'h12, 5'h15, 5'h18, 5'h10},
    '{5'h13, 5'h16, 5'h19, 5'h1F},
    '{5'h1A, 5'h1B, 5'h1C, 5'h1D}
  };

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_valid = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] key_in = 5'h00;
  logic [3:0] cols = 4'h0;
  logic       key_ready, active, busy;
  logic [3:0] rows;
  logic [4:0] code;

  always #5 clk = ~clk;

  keypad_emulator #(.HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_valid(key_valid), .key_ready(key_ready),
    .cols(cols), .rows(rows), .code(code), .active(active), .busy(busy)
`ifdef KEYPAD_EMU_ABORT_EN
    , .abort(abort)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a key queue plus the edge times at which presses start and the engine frees up.
  logic [4:0] m_q[$];
  int         m_start = -1000;
  int         m_free  = 0;
  int         cyc     = -1;
  logic [4:0] m_code  = 5'h00;
  logic [3:0] e_rows;
  logic [4:0] e_code;
  logic       e_active, e_busy, e_ready;
  logic [4:0] press_log[$];
  int         press_time[$];
  logic       last_active = 1'b0;

  typedef struct {
    logic       r;
    logic       kv;
    logic [4:0] k;
    logic [3:0] c;
    logic [3:0] rows;
    logic [4:0] code;
    logic       act;
    logic       busy;
    logic       rdy;
  } vec_t;
  vec_t vt[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout at cyc=%0d", name, cyc);
  endtask

  function automatic logic [7:0] masks(input logic [4:0] c);
    for (int col = 0; col < 4; col++)
      for (int row = 0; row < 4; row++)
        if (c[4] && KEYMAP[col][row] == c) return {4'(1 << col), 4'(1 << row)};
    return 8'h00;
  endfunction

  function automatic bit in_press(input int c);
    return (c >= m_start) && (c < m_start + HOLD);
  endfunction

  function automatic void model_edge();
    int         e = cyc + 1;
    bit         prev_press = in_press(e - 1);
    logic [7:0] mk = masks(m_code);
    bit         rdy_before = (m_q.size() < DEPTH);
    logic [4:0] hd;
    e_rows = (prev_press && ((cols & mk[7:4]) != 4'h0)) ? mk[3:0] : 4'h0;
    if (rst || abort) begin
      m_q.delete();
      m_start = -1000;
      m_free  = e + 1;
      e_rows  = 4'h0;
    end else begin
      if (e >= m_free && m_q.size() > 0) begin
        hd = m_q.pop_front();
        if (hd[4]) begin
          m_start = e;
          m_code  = hd;
          m_free  = e + HOLD + GAP + 1;
        end else begin
          m_free = e + 1;
        end
      end
      if (key_valid && rdy_before) m_q.push_back(key_in);
    end
    cyc      = e;
    e_active = in_press(e);
    e_code   = e_active ? m_code : 5'h00;
    e_busy   = (m_q.size() != 0) || (e < m_free - 1);
    e_ready  = (m_q.size() < DEPTH);
  endfunction

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("rows", rows, e_rows);
    check("code", code, e_code);
    check("active", active, e_active);
    check("busy", busy, e_busy);
    check("key_ready", key_ready, e_ready);
    if (active && !last_active) begin
      press_log.push_back(code);
      press_time.push_back(cyc);
      $display("press code=%h cyc=%0d", code, cyc);
    end
    last_active = active;
  endtask

  function automatic logic [3:0] rand_cols();
    int n = $urandom_range(0, 4);
    return (n == 0) ? 4'h0 : 4'(1 << (n - 1));
  endfunction

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      cols = rand_cols();
      step();
      n++;
    end
    if (busy) timeout(name);
    cols = 4'h0;
  endtask

  task automatic push_seq(input logic [4:0] k);
    key_valid = 1'b1;
    key_in    = k;
    step();
    key_valid = 1'b0;
  endtask

  initial begin
    logic [4:0] burst [5];
    int n;
    burst = '{5'h11, 5'h12, 5'h13, 5'h1A, 5'h1D};

    // Reset and single press of 0x15 (column 2, row 2).
    vt[0]  = '{1'b1, 1'b0, 5'h00, 4'h0, 4'h0, 5'h00, 1'b0, 1'b0, 1'b1};
    vt[1]  = '{1'b1, 1'b0, 5'h00, 4'h0, 4'h0, 5'h00, 1'b0, 1'b0, 1'b1};
    vt[2]  = '{1'b0, 1'b1, 5'h15, 4'h0, 4'h0, 5'h00, 1'b0, 1'b1, 1'b1};
    vt[3]  = '{1'b0, 1'b0, 5'h00, 4'h0, 4'h0, 5'h15, 1'b1, 1'b1, 1'b1};
    vt[4]  = '{1'b0, 1'b0, 5'h00, 4'h2, 4'h2, 5'h15, 1'b1, 1'b1, 1'b1};
    vt[5]  = '{1'b0, 1'b0, 5'h00, 4'h1, 4'h0, 5'h15, 1'b1, 1'b1, 1'b1};
    vt[6]  = '{1'b0, 1'b0, 5'h00, 4'h2, 4'h2, 5'h15, 1'b1, 1'b1, 1'b1};
    vt[7]  = '{1'b0, 1'b0, 5'h00, 4'h0, 4'h0, 5'h15, 1'b1, 1'b1, 1'b1};
    vt[8]  = '{1'b0, 1'b0, 5'h00, 4'h8, 4'h0, 5'h15, 1'b1, 1'b1, 1'b1};
    vt[9]  = '{1'b0, 1'b0, 5'h00, 4'h0, 4'h0, 5'h15, 1'b1, 1'b1, 1'b1};
    vt[10] = '{1'b0, 1'b0, 5'h00, 4'h2, 4'h2, 5'h15, 1'b1, 1'b1, 1'b1};
    vt[11] = '{1'b0, 1'b0, 5'h00, 4'h2, 4'h2, 5'h00, 1'b0, 1'b1, 1'b1};
    vt[12] = '{1'b0, 1'b0, 5'h00, 4'h2, 4'h0, 5'h00, 1'b0, 1'b1, 1'b1};
    vt[13] = '{1'b0, 1'b0, 5'h00, 4'h0, 4'h0, 5'h00, 1'b0, 1'b1, 1'b1};
    vt[14] = '{1'b0, 1'b0, 5'h00, 4'h0, 4'h0, 5'h00, 1'b0, 1'b1, 1'b1};
    vt[15] = '{1'b0, 1'b0, 5'h00, 4'h0, 4'h0, 5'h00, 1'b0, 1'b0, 1'b1};
    vt[16] = '{1'b0, 1'b0, 5'h00, 4'h0, 4'h0, 5'h00, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 17; i++) begin
      rst       = vt[i].r;
      key_valid = vt[i].kv;
      key_in    = vt[i].k;
      cols      = vt[i].c;
      step();
      check("tbl_rows", rows, vt[i].rows);
      check("tbl_code", code, vt[i].code);
      check("tbl_active", active, vt[i].act);
      check("tbl_busy", busy, vt[i].busy);
      check("tbl_ready", key_ready, vt[i].rdy);
    end
    key_valid = 1'b0;
    cols      = 4'h0;

    // Burst of five pushes into a depth-4 queue.
    wait_idle("idle_before_burst");
    press_log.delete();
    press_time.delete();
    for (int i = 0; i < 5; i++) push_seq(burst[i]);
    check("burst_full_ready", key_ready, 1'b0);
    push_seq(5'h1F);
    wait_idle("burst_drain");
    check("burst_count", press_log.size(), 5);
    for (int i = 0; i < 5 && i < press_log.size(); i++) begin
      check("burst_order", press_log[i], burst[i]);
      if (i > 0) check("burst_spacing", press_time[i] - press_time[i-1], HOLD + GAP + 1);
    end

    // Invalid code in the middle is discarded without a press.
    press_log.delete();
    push_seq(5'h11);
    push_seq(5'h07);
    push_seq(5'h1D);
    wait_idle("invalid_drain");
    check("invalid_count", press_log.size(), 2);
    if (press_log.size() == 2) begin
      check("invalid_first", press_log[0], 5'h11);
      check("invalid_second", press_log[1], 5'h1D);
    end

    // Reset in the middle of a press with two codes still queued.
    push_seq(5'h1E);
    push_seq(5'h11);
    push_seq(5'h12);
    n = 0;
    while (!active && n < 50) begin step(); n++; end
    if (!active) timeout("wait_press_1e");
    cols = 4'h1;
    step();
    step();
    check("midpress_rows_before", rows, 4'h8);
    rst = 1'b1;
    step();
    rst  = 1'b0;
    cols = 4'h0;
    check("midpress_rows_after", rows, 4'h0);
    check("midpress_busy_after", busy, 1'b0);
    press_log.delete();
    for (int i = 0; i < 40; i++) begin cols = rand_cols(); step(); end
    check("midpress_no_more", press_log.size(), 0);

`ifdef KEYPAD_EMU_ABORT_EN
    push_seq(5'h10);
    push_seq(5'h11);
    push_seq(5'h12);
    cols = 4'h2;
    step();
    check("abort_rows_before", rows, 4'h8);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_rows_after", rows, 4'h0);
    check("abort_ready", key_ready, 1'b1);
    check("abort_busy", busy, 1'b0);
    cols = 4'h0;
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      key_valid = ($urandom % 3) == 0;
      key_in    = {($urandom % 5) != 0, 4'($urandom)};
      cols      = rand_cols();
      rst       = ($urandom % 400) == 0;
`ifdef KEYPAD_EMU_ABORT_EN
      abort     = ($urandom % 300) == 0;
`endif
      step();
    end
    rst       = 1'b0;
    abort     = 1'b0;
    key_valid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
